mux_n1_reg: RTL and testbench

MUX_N1_REG -- requirements
Module: mux_n1_reg

---
 rtl/mux_n1_reg.sv | 72 +++++++
 tb/tb_mux_n1_reg.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_n1_reg.sv
// mux_n1_reg: N-to-1 mux into a one-entry output register.
// The channel is chosen by explicit select (MODE=0) or by round-robin arbitration (MODE=1).
module mux_n1_reg #(
  parameter int WIDTH = 5,
  parameter int NUM_IN = 4,
  parameter int MODE = 0,
  localparam int SEL_W = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
  input  logic                    Clk_,
  input  logic                    Rst_,
  input  logic [NUM_IN*WIDTH-1:0] InpData_,
  input  logic [NUM_IN-1:0]       InpValid_,
  output logic [NUM_IN-1:0]       InpReady_,
  input  logic [SEL_W-1:0]        Sel_,
  output logic [WIDTH-1:0]        Out_,
  output logic                    OutValid_,
  input  logic                    OutReady_,
  output logic [SEL_W-1:0]        Grant_
);
  logic [WIDTH-1:0] out_q, out_d, din;
  logic vld_q, vld_d;
  logic [SEL_W-1:0] grant_q, grant_d, ptr_q, ptr_d, cand;
  logic [NUM_IN-1:0] rot;
  logic [SEL_W:0] sum;
  logic found, space, xfer;
  // rot holds the valids rotated so that bit 0 is the channel at Ptr
  always_comb begin
    rot = NUM_IN'({InpValid_, InpValid_} >> ptr_q);
    cand = '0;
    found = 1'b0;
    sum = '0;
    if (MODE == 0) begin
      cand = Sel_;
      found = {1'b0, Sel_} < (SEL_W+1)'(NUM_IN);
    end else begin
      for (int i = 0; i < NUM_IN; i++) begin
        if (!found && rot[i]) begin
          found = 1'b1;
          sum = (SEL_W+1)'(ptr_q) + (SEL_W+1)'(i);
          cand = (sum >= (SEL_W+1)'(NUM_IN)) ? SEL_W'(sum - (SEL_W+1)'(NUM_IN)) : SEL_W'(sum);
        end
      end
    end
    // during reset the register is treated as empty for the ready computation
    space = !Rst_ | !vld_q | OutReady_;
    InpReady_ = (found && space) ? NUM_IN'(1) << cand : '0;
    xfer = |(InpReady_ & InpValid_);
    din = '0;
    for (int i = 0; i < NUM_IN; i++)
      if (cand == SEL_W'(i)) din = InpData_[i*WIDTH +: WIDTH];
    vld_d = xfer | (vld_q & !OutReady_);
    out_d = xfer ? din : out_q;
    grant_d = xfer ? cand : grant_q;
    ptr_d = (MODE == 1 && xfer) ? ((cand == SEL_W'(NUM_IN-1)) ? '0 : cand + 1'b1) : ptr_q;
  end
  always_ff @(posedge Clk_) begin
    if (!Rst_) begin
      out_q <= '0;
      vld_q <= 1'b0;
      grant_q <= '0;
      ptr_q <= '0;
    end else begin
      out_q <= out_d;
      vld_q <= vld_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
    end
  end
  assign Out_ = out_q;
  assign OutValid_ = vld_q;
  assign Grant_ = grant_q;
endmodule

// File: tb/tb_mux_n1_reg.sv
// tb_mux_n1_reg: scenario tasks over three configurations of mux_n1_reg,
// explicit select (4x5), round-robin (4x5) and explicit select (2x32) with a scoreboard.
module tb_mux_n1_reg;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;

  logic [19:0] a_data;
  logic [3:0] a_valid, a_ready;
  logic [1:0] a_sel, a_grant;
  logic [4:0] a_out;
  logic a_ov, a_or;
  mux_n1_reg #(.WIDTH(5), .NUM_IN(4), .MODE(0)) dut_a (
    .Clk_(clk), .Rst_(rst), .InpData_(a_data), .InpValid_(a_valid), .InpReady_(a_ready),
    .Sel_(a_sel), .Out_(a_out), .OutValid_(a_ov), .OutReady_(a_or), .Grant_(a_grant));

  logic [19:0] b_data;
  logic [3:0] b_valid, b_ready;
  logic [1:0] b_sel, b_grant;
  logic [4:0] b_out;
  logic b_ov, b_or;
  mux_n1_reg #(.WIDTH(5), .NUM_IN(4), .MODE(1)) dut_b (
    .Clk_(clk), .Rst_(rst), .InpData_(b_data), .InpValid_(b_valid), .InpReady_(b_ready),
    .Sel_(b_sel), .Out_(b_out), .OutValid_(b_ov), .OutReady_(b_or), .Grant_(b_grant));

  logic [63:0] c_data;
  logic [1:0] c_valid, c_ready;
  logic c_sel, c_grant;
  logic [31:0] c_out;
  logic c_ov, c_or;
  mux_n1_reg #(.WIDTH(32), .NUM_IN(2), .MODE(0)) dut_c (
    .Clk_(clk), .Rst_(rst), .InpData_(c_data), .InpValid_(c_valid), .InpReady_(c_ready),
    .Sel_(c_sel), .Out_(c_out), .OutValid_(c_ov), .OutReady_(c_or), .Grant_(c_grant));

  logic [32:0] sb[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    checks++;
    if ({a_ov, a_out, a_grant} !== 8'h0) begin errors++; $display("FAIL reset_a: got %h want 0", {a_ov, a_out, a_grant}); end
    checks++;
    if ({b_ov, b_out, b_grant} !== 8'h0) begin errors++; $display("FAIL reset_b: got %h want 0", {b_ov, b_out, b_grant}); end
    checks++;
    if ({c_ov, c_out, c_grant} !== 34'h0) begin errors++; $display("FAIL reset_c: got %h want 0", {c_ov, c_out, c_grant}); end
    rst = 1'b1;
  endtask

  task automatic test_select();
    a_sel = 2'd2;
    a_valid = 4'b0100;
    a_data = 20'h15 << 10;
    a_or = 1'b1;
    #1;
    checks++;
    if (a_ready !== 4'b0100) begin errors++; $display("FAIL sel_ready: got %b want 0100", a_ready); end
    tick();
    checks++;
    if ({a_ov, a_out, a_grant} !== {1'b1, 5'h15, 2'd2}) begin errors++; $display("FAIL sel_load: got %h want %h", {a_ov, a_out, a_grant}, {1'b1, 5'h15, 2'd2}); end
  endtask

  task automatic test_hold();
    a_sel = 2'd3;
    a_valid = 4'b1000;
    a_data = 20'h0A << 15;
    a_or = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (a_ready !== 4'b0000) begin errors++; $display("FAIL hold_ready %0d: got %b want 0000", i, a_ready); end
      tick();
      checks++;
      if ({a_ov, a_out, a_grant} !== {1'b1, 5'h15, 2'd2}) begin errors++; $display("FAIL hold_out %0d: got %h want %h", i, {a_ov, a_out, a_grant}, {1'b1, 5'h15, 2'd2}); end
    end
    a_or = 1'b1;
    #1;
    checks++;
    if (a_ready !== 4'b1000) begin errors++; $display("FAIL release_ready: got %b want 1000", a_ready); end
    tick();
    checks++;
    if ({a_ov, a_out, a_grant} !== {1'b1, 5'h0A, 2'd3}) begin errors++; $display("FAIL reload: got %h want %h", {a_ov, a_out, a_grant}, {1'b1, 5'h0A, 2'd3}); end
    a_valid = 4'b0000;
    tick();
    checks++;
    if ({a_ov, a_out, a_grant} !== {1'b0, 5'h0A, 2'd3}) begin errors++; $display("FAIL drain_hold: got %h want %h", {a_ov, a_out, a_grant}, {1'b0, 5'h0A, 2'd3}); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_g;
    b_data = {5'd4, 5'd3, 5'd2, 5'd1};
    b_valid = 4'b1111;
    b_or = 1'b1;
    #1;
    checks++;
    if (b_ready !== 4'b0001) begin errors++; $display("FAIL rr_ready0: got %b want 0001", b_ready); end
    for (int i = 0; i < 6; i++) begin
      tick();
      exp_g = 2'(i % 4);
      checks++;
      if ({b_ov, b_out, b_grant} !== {1'b1, 5'(exp_g) + 5'd1, exp_g}) begin errors++; $display("FAIL rr_grant %0d: got %h want %h", i, {b_ov, b_out, b_grant}, {1'b1, 5'(exp_g) + 5'd1, exp_g}); end
    end
    b_valid = 4'b0000;
    tick();
    checks++;
    if (b_ov !== 1'b0) begin errors++; $display("FAIL rr_drain: got %b want 0", b_ov); end
  endtask

  task automatic test_sparse();
    logic [1:0] exp_g[3] = '{2'd3, 2'd1, 2'd3};
    b_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (b_ready !== 4'b0001 << exp_g[i]) begin errors++; $display("FAIL sparse_ready %0d: got %b want %b", i, b_ready, 4'b0001 << exp_g[i]); end
      tick();
      checks++;
      if ({b_ov, b_out, b_grant} !== {1'b1, 5'(exp_g[i]) + 5'd1, exp_g[i]}) begin errors++; $display("FAIL sparse_grant %0d: got %h want %h", i, {b_ov, b_out, b_grant}, {1'b1, 5'(exp_g[i]) + 5'd1, exp_g[i]}); end
    end
  endtask

  task automatic test_reset_midstream();
    b_valid = 4'b1111;
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (b_ready !== 4'b0010) begin errors++; $display("FAIL rst_ready: got %b want 0010", b_ready); end
    tick();
    checks++;
    if ({b_ov, b_out, b_grant} !== 8'h0) begin errors++; $display("FAIL rst_mid: got %h want 0", {b_ov, b_out, b_grant}); end
    rst = 1'b1;
    #1;
    checks++;
    if (b_ready !== 4'b0001) begin errors++; $display("FAIL rst_ptr: got %b want 0001", b_ready); end
    tick();
    checks++;
    if ({b_ov, b_out, b_grant} !== {1'b1, 5'd1, 2'd0}) begin errors++; $display("FAIL rst_first: got %h want %h", {b_ov, b_out, b_grant}, {1'b1, 5'd1, 2'd0}); end
    b_valid = 4'b0000;
  endtask

  task automatic test_back_to_back();
    logic [1:0] exp_r;
    logic [32:0] exp_w;
    int pops = 0;
    c_sel = 1'b0;
    for (int i = 0; i < 300; i++) begin
      checks++;
      if (c_ov !== (sb.size() != 0)) begin errors++; $display("FAIL sb_valid %0d: got %b want %b", i, c_ov, sb.size() != 0); end
      c_sel = ~c_sel;
      c_or = 1'($urandom_range(0, 1));
      c_valid = 2'($urandom_range(0, 3));
      c_data = {$urandom, $urandom};
      #1;
      exp_r = (sb.size() == 0 || c_or) ? 2'b01 << c_sel : 2'b00;
      checks++;
      if (c_ready !== exp_r) begin errors++; $display("FAIL sb_ready %0d: got %b want %b", i, c_ready, exp_r); end
      if (sb.size() != 0 && c_or) begin
        exp_w = sb.pop_front();
        pops++;
        checks++;
        if ({c_grant, c_out} !== exp_w) begin errors++; $display("FAIL sb_data %0d: got %h want %h", i, {c_grant, c_out}, exp_w); end
      end
      if ((exp_r & c_valid) != 2'b00) sb.push_back({c_sel, c_sel ? c_data[63:32] : c_data[31:0]});
      tick();
    end
    checks++;
    if (pops < 50) begin errors++; $display("FAIL sb_pops: got %0d want >=50", pops); end
  endtask

  initial begin
    a_data = '0; a_valid = '0; a_sel = '0; a_or = 1'b0;
    b_data = '0; b_valid = '0; b_sel = '0; b_or = 1'b0;
    c_data = '0; c_valid = '0; c_sel = 1'b0; c_or = 1'b0;
    test_reset();
    test_select();
    test_hold();
    test_round_robin();
    test_sparse();
    test_reset_midstream();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
